// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the cache-to-memory arbiter.
// Holds the FSM state enum, the owner encoding, and the default line/beat
// geometry that the I-cache and D-cache refill paths also use.
package mem_arb_pkg;

  // Default memory geometry, reused by both caches
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_BEATS  = 4;

  // Arbiter transaction phases
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Which cache owns the transaction in flight
  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every cache-side and memory-side signal of the arbiter.
// Modport master: the arbiter's view (takes cache requests, masters memory).
// Modport slave:  the environment's view (caches plus main memory).
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
) ();

  // I-cache side
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;

  // D-cache side
  logic                 dc_req_valid;
  logic                dc_req_rw;
  logic [ADDR_W-1:0]   dc_req_addr;
  logic [DATA_W-1:0]   dc_req_wdata;
  logic [DATA_W/8-1:0] dc_req_wmask;
  logic                dc_req_ready;
  logic                dc_resp_valid;
  logic [DATA_W-1:0]   dc_resp_data;
  logic                dc_wr_done;

  // Memory request, write-data and read-beat channels
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_rw;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic                mem_req_data_valid;
  logic                mem_req_data_ready;
  logic [DATA_W-1:0]   mem_req_data_bits;
  logic [DATA_W/8-1:0] mem_req_data_mask;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   mem_resp_data;

  modport master (
    input  ic_req_valid, ic_req_addr,
    output ic_req_ready, ic_resp_valid, ic_resp_data,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
    output dc_req_ready, dc_resp_valid, dc_resp_data, dc_wr_done,
    output mem_req_valid, mem_req_rw, mem_req_addr,
    input  mem_req_ready,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_data_ready,
    input  mem_resp_valid, mem_resp_data
  );

  modport slave (
    output ic_req_valid, ic_req_addr,
    input  ic_req_ready, ic_resp_valid, ic_resp_data,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
    input  dc_req_ready, dc_resp_valid, dc_resp_data, dc_wr_done,
    input  mem_req_valid, mem_req_rw, mem_req_addr,
    output mem_req_ready,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_data_ready,
    output mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports: req_ic_i/req_dc_i request lines, last_grant_i previous winner,
//        gnt_valid_o any grant this cycle, gnt_owner_o the winner.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic   req_ic_i,
  input  logic   req_dc_i,
  input  owner_e last_grant_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

  // A lone requester always wins; on a tie the side not granted last wins
  always_comb begin
    gnt_valid_o = req_ic_i | req_dc_i;
    gnt_owner_o = OWN_IC;
    if (req_ic_i && req_dc_i) begin
      gnt_owner_o = (last_grant_i == OWN_IC) ? OWN_DC : OWN_IC;
    end else if (req_dc_i) begin
      gnt_owner_o = OWN_DC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between I-cache and D-cache.
// One transaction at a time: accept, issue request, then either push one
// write beat or route BEATS read beats back to the owning cache.
// Ports: clk, reset (sync, active-high), bus (mem_arbiter_if.master).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BEATS  = DEF_BEATS
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.master bus
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;

  logic   gnt_valid;
  owner_e gnt_owner;

  rr_arb2 u_rr_arb2 (
    .req_ic_i    (bus.ic_req_valid),
    .req_dc_i    (bus.dc_req_valid),
    .last_grant_i(last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  // State and captured-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IC;
      last_q     <= OWN_IC;
      beat_cnt_q <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
    end
  end

  // Next-state and outputs. Outputs are held at zero while reset is high,
  // so an abandoned transaction cannot leak a beat or accept pulse.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;

    bus.ic_req_ready       = 1'b0;
    bus.ic_resp_valid      = 1'b0;
    bus.ic_resp_data       = '0;
    bus.dc_req_ready       = 1'b0;
    bus.dc_resp_valid      = 1'b0;
    bus.dc_resp_data       = '0;
    bus.dc_wr_done         = 1'b0;
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_rw         = 1'b0;
    bus.mem_req_addr       = '0;
    bus.mem_req_data_valid = 1'b0;
    bus.mem_req_data_bits  = '0;
    bus.mem_req_data_mask  = '0;

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_d = gnt_owner;
            last_d  = gnt_owner;
            state_d = REQ;
            if (gnt_owner == OWN_DC) begin
              bus.dc_req_ready = 1'b1;
              rw_d    = bus.dc_req_rw;
              addr_d  = bus.dc_req_addr;
              wdata_d = bus.dc_req_wdata;
              wmask_d = bus.dc_req_wmask;
            end else begin
              bus.ic_req_ready = 1'b1;
              rw_d    = 1'b0;
              addr_d  = bus.ic_req_addr;
              wdata_d = '0;
              wmask_d = '0;
            end
          end
        end
        REQ: begin
          bus.mem_req_valid = 1'b1;
          bus.mem_req_rw    = rw_q;
          bus.mem_req_addr  = addr_q;
          if (bus.mem_req_ready) begin
            beat_cnt_d = '0;
            state_d    = rw_q ? WDATA : RESP;
          end
        end
        WDATA: begin
          bus.mem_req_data_valid = 1'b1;
          bus.mem_req_data_bits  = wdata_q;
          bus.mem_req_data_mask  = wmask_q;
          if (bus.mem_req_data_ready) begin
            bus.dc_wr_done = 1'b1;
            state_d        = IDLE;
          end
        end
        RESP: begin
          if (bus.mem_resp_valid) begin
            if (owner_q == OWN_DC) begin
              bus.dc_resp_valid = 1'b1;
              bus.dc_resp_data  = bus.mem_resp_data;
            end else begin
              bus.ic_resp_valid = 1'b1;
              bus.ic_resp_data  = bus.mem_resp_data;
            end
            // Clear on the last beat so the counter is zero for the next read
            if (beat_cnt_q == LAST_BEAT) begin
              beat_cnt_d = '0;
              state_d    = IDLE;
            end else begin
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of arbitration vectors,
// hand-written corner sequences, and a randomized run against a
// round-robin reference model. Inputs change and outputs are sampled
// around the falling clock edge, away from the active rising edge.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int NB = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   modelLast;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BEATS(NB)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int icV;
    int dcV;
    int rw;
    int expOwner;
  } vec_t;

  vec_t vecs[7];

  // Single comparison point: counts every check, reports any miss
  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, actual, expected);
    end
  endtask

  // Reference rule: lone requester wins, ties go to the side not granted last
  function automatic int predictGrant(input int icV, input int dcV, input int last);
    if (icV != 0 && dcV == 0) return 0;
    if (dcV != 0 && icV == 0) return 1;
    if (icV != 0 && dcV != 0) return 1 - last;
    return -1;
  endfunction

  // Idle-side defaults for every input the bench drives
  task automatic clearInputs();
    bus.ic_req_valid       = 1'b0;
    bus.ic_req_addr        = '0;
    bus.dc_req_valid       = 1'b0;
    bus.dc_req_rw          = 1'b0;
    bus.dc_req_addr        = '0;
    bus.dc_req_wdata       = '0;
    bus.dc_req_wmask       = '0;
    bus.mem_req_ready      = 1'b0;
    bus.mem_req_data_ready = 1'b0;
    bus.mem_resp_valid     = 1'b0;
    bus.mem_resp_data      = '0;
  endtask

  // One complete transaction starting in an IDLE cycle just after a falling
  // edge; memory stalls the request and write-data channels by the given
  // delays and returns read beats beatBase, beatBase+1, ...
  task automatic applyStimulus(input string tag, input int icV, input int dcV,
                               input int rw, input logic [AW-1:0] icA,
                               input logic [AW-1:0] dcA, input logic [DW-1:0] wd,
                               input logic [DW/8-1:0] wm, input int reqDelay,
                               input int dataDelay, input logic [DW-1:0] beatBase,
                               input int expOwner);
    logic            expRw;
    logic [AW-1:0]   expA;
    logic [DW-1:0]   beat;
    bus.ic_req_valid = (icV != 0);
    bus.ic_req_addr  = icA;
    bus.dc_req_valid = (dcV != 0);
    bus.dc_req_rw    = (rw != 0);
    bus.dc_req_addr  = dcA;
    bus.dc_req_wdata = wd;
    bus.dc_req_wmask = wm;
    #1;
    checkOutput({tag, ".icReady"}, bus.ic_req_ready, (expOwner == 0));
    checkOutput({tag, ".dcReady"}, bus.dc_req_ready, (expOwner == 1));
    @(negedge clk);
    bus.ic_req_valid = 1'b0;
    bus.dc_req_valid = 1'b0;
    if (expOwner < 0) begin
      #1;
      checkOutput({tag, ".noGrantIdle"}, bus.mem_req_valid, 1'b0);
      return;
    end
    modelLast = expOwner;
    expRw = (expOwner == 1) && (rw != 0);
    expA  = (expOwner == 1) ? dcA : icA;
    for (int i = 0; i < reqDelay; i++) begin
      #1;
      checkOutput({tag, ".reqHoldValid"}, bus.mem_req_valid, 1'b1);
      checkOutput({tag, ".reqHoldAddr"}, bus.mem_req_addr, expA);
      checkOutput({tag, ".reqHoldRw"}, bus.mem_req_rw, expRw);
      checkOutput({tag, ".noAcceptPulse"}, bus.ic_req_ready | bus.dc_req_ready, 1'b0);
      @(negedge clk);
    end
    #1;
    checkOutput({tag, ".reqValid"}, bus.mem_req_valid, 1'b1);
    checkOutput({tag, ".reqAddr"}, bus.mem_req_addr, expA);
    checkOutput({tag, ".reqRw"}, bus.mem_req_rw, expRw);
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    if (expRw) begin
      for (int i = 0; i < dataDelay; i++) begin
        #1;
        checkOutput({tag, ".wdHoldValid"}, bus.mem_req_data_valid, 1'b1);
        checkOutput({tag, ".wdEarlyDone"}, bus.dc_wr_done, 1'b0);
        @(negedge clk);
      end
      #1;
      checkOutput({tag, ".wdValid"}, bus.mem_req_data_valid, 1'b1);
      checkOutput({tag, ".wdBits"}, bus.mem_req_data_bits, wd);
      checkOutput({tag, ".wdMask"}, bus.mem_req_data_mask, wm);
      bus.mem_req_data_ready = 1'b1;
      #1;
      checkOutput({tag, ".wrDone"}, bus.dc_wr_done, 1'b1);
      @(negedge clk);
      bus.mem_req_data_ready = 1'b0;
      #1;
      checkOutput({tag, ".wrDoneOnce"}, bus.dc_wr_done, 1'b0);
      checkOutput({tag, ".wdDropped"}, bus.mem_req_data_valid, 1'b0);
    end else begin
      for (int b = 0; b < NB; b++) begin
        beat = beatBase + DW'(b);
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = beat;
        #1;
        checkOutput({tag, ".icRespValid"}, bus.ic_resp_valid, (expOwner == 0));
        checkOutput({tag, ".dcRespValid"}, bus.dc_resp_valid, (expOwner == 1));
        checkOutput({tag, ".respData"},
                    (expOwner == 0) ? bus.ic_resp_data : bus.dc_resp_data, beat);
        @(negedge clk);
      end
      bus.mem_resp_valid = 1'b0;
      #1;
    end
    checkOutput({tag, ".backIdle"}, bus.mem_req_valid, 1'b0);
  endtask

  // Every arbiter output must read zero
  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".readies"}, {bus.ic_req_ready, bus.dc_req_ready}, '0);
    checkOutput({tag, ".respValids"}, {bus.ic_resp_valid, bus.dc_resp_valid, bus.dc_wr_done}, '0);
    checkOutput({tag, ".memValids"}, {bus.mem_req_valid, bus.mem_req_data_valid, bus.mem_req_rw}, '0);
    checkOutput({tag, ".memAddr"}, bus.mem_req_addr, '0);
    checkOutput({tag, ".memBits"}, bus.mem_req_data_bits, '0);
    checkOutput({tag, ".memMask"}, bus.mem_req_data_mask, '0);
    checkOutput({tag, ".respData"}, bus.ic_resp_data | bus.dc_resp_data, '0);
  endtask

  // Main test sequence
  initial begin
    logic [DW-1:0] wdPattern;
    total     = 0;
    bad       = 0;
    modelLast = 0;
    reset     = 1'b1;
    clearInputs();

    // Arbitration table from reset; last grant starts at I-cache
    vecs[0] = '{icV: 1, dcV: 1, rw: 0, expOwner: 1};
    vecs[1] = '{icV: 1, dcV: 1, rw: 0, expOwner: 0};
    vecs[2] = '{icV: 1, dcV: 0, rw: 1, expOwner: 0};
    vecs[3] = '{icV: 1, dcV: 1, rw: 1, expOwner: 1};
    vecs[4] = '{icV: 0, dcV: 1, rw: 1, expOwner: 1};
    vecs[5] = '{icV: 1, dcV: 1, rw: 0, expOwner: 0};
    vecs[6] = '{icV: 0, dcV: 0, rw: 0, expOwner: -1};

    // Reset: outputs zero even with a request pending
    repeat (2) @(negedge clk);
    bus.ic_req_valid = 1'b1;
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;
    bus.ic_req_valid = 1'b0;
    #1;
    checkAllZero("afterReset");

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].icV, vecs[i].dcV, vecs[i].rw,
                    28'h0000100 + AW'(i), 28'h0000200 + AW'(i), {4{32'h1234_5678}},
                    16'h00FF, 0, 0, 128'h50 + DW'(i * 8), vecs[i].expOwner);
    end

    // I-cache read of beats A0..A3
    applyStimulus("icRead", 1, 0, 0, 28'h0000100, '0, '0, '0, 0, 0, 128'hA0, 0);

    // D-cache write with write-data ready held off 3 cycles
    wdPattern = {4{32'hDEAD_BEEF}};
    applyStimulus("dcWrite", 0, 1, 1, '0, 28'h0000200, wdPattern, 16'hFFFF,
                  0, 3, '0, 1);

    // Memory request channel stalled 5 cycles
    applyStimulus("reqStall", 1, 0, 0, 28'h0ABCDEF, '0, '0, '0, 5, 0, 128'h70, 0);

    // Reset after two of four beats abandons the read
    bus.ic_req_valid = 1'b1;
    bus.ic_req_addr  = 28'h0000300;
    #1;
    checkOutput("rstSeq.accept", bus.ic_req_ready, 1'b1);
    @(negedge clk);
    bus.ic_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 128'hB0 + DW'(b);
      #1;
      checkOutput("rstSeq.beatBefore", bus.ic_resp_valid, 1'b1);
      @(negedge clk);
    end
    reset = 1'b1;
    bus.mem_resp_data = 128'hB2;
    #1;
    checkOutput("rstSeq.beatDuringReset", bus.ic_resp_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_resp_data = 128'hB3;
    #1;
    checkAllZero("rstSeq.lateBeat");
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    modelLast = 0;
    applyStimulus("rstSeq.newReq", 1, 0, 0, 28'h0000400, '0, '0, '0, 0, 0, 128'hC0, 0);

    // Spurious beats in IDLE are ignored and do not advance the beat count
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = 128'hEE;
      #1;
      checkOutput("spurious.respValid", {bus.ic_resp_valid, bus.dc_resp_valid}, '0);
      @(negedge clk);
    end
    bus.mem_resp_valid = 1'b0;
    applyStimulus("spurious.read", 0, 1, 0, '0, 28'h0000500, '0, '0, 0, 0, 128'hD0, 1);

    // Randomized traffic against the round-robin reference model
    for (int n = 0; n < 40; n++) begin
      int icV, dcV, rw, expOwner;
      icV = int'($urandom_range(0, 1));
      dcV = int'($urandom_range(0, 1));
      rw  = int'($urandom_range(0, 1));
      expOwner = predictGrant(icV, dcV, modelLast);
      applyStimulus($sformatf("rand%0d", n), icV, dcV, rw, AW'($urandom), AW'($urandom),
                    {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    {96'h0, $urandom}, expOwner);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
